// File: rtl/tqvp_prism_in_pkg.sv
// rtl/tqvp_prism_in_pkg.sv - shared offsets, field positions and FIFO entry type for the input capture stage
package tqvp_prism_in_pkg;

  localparam logic [5:0] ADDR_CTRL   = 6'h00;
  localparam logic [5:0] ADDR_STATUS = 6'h04;
  localparam logic [5:0] ADDR_EVENT  = 6'h08;
  localparam logic [5:0] ADDR_TS     = 6'h0C;

  localparam int FIFO_DEPTH_DEF = 4;
  localparam int TS_W_DEF       = 16;
  localparam int FILT_LEN_W     = 4;
  localparam int N_IN           = 7;

  localparam int CTRL_FILT_LSB   = 0;
  localparam int CTRL_PRESC_LSB  = 4;
  localparam int CTRL_RISE_LSB   = 8;
  localparam int CTRL_FALL_LSB   = 16;
  localparam int CTRL_IRQ_EN_BIT = 31;

  localparam int STAT_COUNT_LSB = 0;
  localparam int STAT_COUNT_W   = 3;
  localparam int STAT_OVF_BIT   = 3;
  localparam int STAT_RISE_LSB  = 8;
  localparam int STAT_FALL_LSB  = 16;

  localparam int EV_TS_LSB    = 0;
  localparam int EV_IDX_LSB   = 16;
  localparam int EV_LEVEL_BIT = 20;
  localparam int EV_VALID_BIT = 31;

  typedef struct packed {
    logic                level;
    logic [2:0]          idx;
    logic [TS_W_DEF-1:0] ts;
  } fifo_entry_t;

endpackage

// File: rtl/tqvp_prism_in_filter.sv
// rtl/tqvp_prism_in_filter.sv - one-bit glitch filter with programmable stability length
module tqvp_prism_in_filter
  import tqvp_prism_in_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  raw,
  input  logic                  clr,
  input  logic [FILT_LEN_W-1:0] filt_len,
  output logic                  filt,
  output logic                  fire
);

  logic [FILT_LEN_W-1:0] cnt;

  // fire marks the clock edge on which filt takes the raw value
  assign fire = (raw != filt) && (cnt == filt_len);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt  <= '0;
      filt <= 1'b0;
    end else if (fire) begin
      filt <= raw;
      cnt  <= '0;
    end else if (clr || raw == filt) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + FILT_LEN_W'(1);
    end
  end

endmodule

// File: rtl/tqvp_prism_in_capture.sv
// rtl/tqvp_prism_in_capture.sv - filtered PMOD inputs with sticky edge flags and a timestamped event FIFO
module tqvp_prism_in_capture
  import tqvp_prism_in_pkg::*;
#(
  parameter int FIFO_DEPTH = FIFO_DEPTH_DEF,
  parameter int TS_W       = TS_W_DEF
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [6:0]      ui_in,
  input  logic [5:0]      address,
  input  logic [31:0]     data_in,
  input  logic [1:0]      data_write_n,
  input  logic [1:0]      data_read_n,
  output logic [31:0]     data_out,
  output logic            data_ready,
  output logic [6:0]      filt_out,
  output logic            irq
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;

  logic [FILT_LEN_W-1:0] filt_len, presc, presc_cnt;
  logic [N_IN-1:0]       rise_en, fall_en, rise_flag, fall_flag;
  logic                  irq_en, ovf;
  logic [TS_W-1:0]       ts;
  fifo_entry_t           mem [FIFO_DEPTH];
  fifo_entry_t           head, new_entry;
  logic [PW-1:0]         wptr, rptr;
  logic [CW-1:0]         count;

  logic            wr_ctrl, wr_status, pop, push_req, push_ok, extra, full;
  logic [N_IN-1:0] fire, rise_ev, fall_ev, req;
  logic [2:0]      push_idx;
  logic            unused_data;

  assign wr_ctrl   = (data_write_n == 2'b10) && (address == ADDR_CTRL);
  assign wr_status = (data_write_n == 2'b10) && (address == ADDR_STATUS);
  assign full      = (count == CW'(FIFO_DEPTH));
  assign pop       = (data_read_n == 2'b10) && (address == ADDR_EVENT) && (count != '0);

  for (genvar i = 0; i < N_IN; i++) begin : g_filt
    tqvp_prism_in_filter u_filt (
      .clk      (clk),
      .rst_n    (rst_n),
      .raw      (ui_in[i]),
      .clr      (wr_ctrl),
      .filt_len (filt_len),
      .filt     (filt_out[i]),
      .fire     (fire[i])
    );
  end

  assign rise_ev = fire & ui_in;
  assign fall_ev = fire & ~ui_in;
  assign req     = (rise_ev & rise_en) | (fall_ev & fall_en);

  // Lowest enabled index wins the single push slot; the rest count as lost
  always_comb begin
    push_req = 1'b0;
    push_idx = '0;
    extra    = 1'b0;
    for (int i = 0; i < N_IN; i++) begin
      if (req[i]) begin
        if (push_req) begin
          extra = 1'b1;
        end else begin
          push_req = 1'b1;
          push_idx = 3'(i);
        end
      end
    end
  end

  // A pop frees the slot the same edge, so a push into a full FIFO still fits
  assign push_ok         = push_req && (!full || pop);
  assign new_entry.level = ui_in[push_idx];
  assign new_entry.idx   = push_idx;
  assign new_entry.ts    = TS_W_DEF'(ts);
  assign head            = mem[rptr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      filt_len <= '0;
      presc    <= '0;
      rise_en  <= '0;
      fall_en  <= '0;
      irq_en   <= 1'b0;
    end else if (wr_ctrl) begin
      filt_len <= data_in[CTRL_FILT_LSB +: FILT_LEN_W];
      presc    <= data_in[CTRL_PRESC_LSB +: FILT_LEN_W];
      rise_en  <= data_in[CTRL_RISE_LSB +: N_IN];
      fall_en  <= data_in[CTRL_FALL_LSB +: N_IN];
      irq_en   <= data_in[CTRL_IRQ_EN_BIT];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovf       <= 1'b0;
      rise_flag <= '0;
      fall_flag <= '0;
    end else begin
      ovf       <= (ovf & ~(wr_status & data_in[STAT_OVF_BIT])) | extra | (push_req & ~push_ok);
      rise_flag <= (rise_flag & ~(wr_status ? data_in[STAT_RISE_LSB +: N_IN] : '0)) | rise_ev;
      fall_flag <= (fall_flag & ~(wr_status ? data_in[STAT_FALL_LSB +: N_IN] : '0)) | fall_ev;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      presc_cnt <= '0;
      ts        <= '0;
    end else if (presc_cnt >= presc) begin
      presc_cnt <= '0;
      ts        <= ts + TS_W'(1);
    end else begin
      presc_cnt <= presc_cnt + FILT_LEN_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) mem[i] <= '0;
    end else begin
      if (push_ok) begin
        mem[wptr] <= new_entry;
        wptr      <= wptr + PW'(1);
      end
      if (pop) rptr <= rptr + PW'(1);
      count <= count + CW'(push_ok) - CW'(pop);
    end
  end

  always_comb begin
    data_out = '0;
    case (address)
      ADDR_CTRL: begin
        data_out[CTRL_FILT_LSB +: FILT_LEN_W]  = filt_len;
        data_out[CTRL_PRESC_LSB +: FILT_LEN_W] = presc;
        data_out[CTRL_RISE_LSB +: N_IN]        = rise_en;
        data_out[CTRL_FALL_LSB +: N_IN]        = fall_en;
        data_out[CTRL_IRQ_EN_BIT]              = irq_en;
      end
      ADDR_STATUS: begin
        data_out[STAT_COUNT_LSB +: STAT_COUNT_W] = STAT_COUNT_W'(count);
        data_out[STAT_OVF_BIT]                   = ovf;
        data_out[STAT_RISE_LSB +: N_IN]          = rise_flag;
        data_out[STAT_FALL_LSB +: N_IN]          = fall_flag;
      end
      ADDR_EVENT: begin
        if (count != '0) begin
          data_out[EV_VALID_BIT]             = 1'b1;
          data_out[EV_LEVEL_BIT]             = head.level;
          data_out[EV_IDX_LSB +: 3]          = head.idx;
          data_out[EV_TS_LSB +: TS_W_DEF]    = head.ts;
        end
      end
      ADDR_TS: data_out = 32'(ts);
      default: data_out = '0;
    endcase
  end

  assign irq         = irq_en & ((count != '0) | ovf);
  assign data_ready  = 1'b1;
  assign unused_data = ^{data_in[30:23], data_in[15]};

endmodule

// File: tb/tb_tqvp_prism_in_capture.sv
// tb/tb_tqvp_prism_in_capture.sv - self-checking bench with a behavioural model of the capture stage
module tb_tqvp_prism_in_capture;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [6:0]  ui_in = '0;
  logic [5:0]  address = '0;
  logic [31:0] data_in = '0;
  logic [1:0]  data_write_n = 2'b11;
  logic [1:0]  data_read_n = 2'b11;
  logic [31:0] data_out;
  logic        data_ready;
  logic [6:0]  filt_out;
  logic        irq;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  tqvp_prism_in_capture dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .ui_in        (ui_in),
    .address      (address),
    .data_in      (data_in),
    .data_write_n (data_write_n),
    .data_read_n  (data_read_n),
    .data_out     (data_out),
    .data_ready   (data_ready),
    .filt_out     (filt_out),
    .irq          (irq)
  );

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", name, got, exp);
    end
  endtask

  // Model: events as a queue, filter as a run length of differing samples
  typedef struct {
    bit        level;
    bit [2:0]  idx;
    bit [15:0] ts;
  } ev_t;

  localparam int DEPTH = 4;
  ev_t       mq[$];
  int        m_n, m_p, m_pc, cyc;
  int        m_run[7];
  bit [6:0]  m_ren, m_fen, m_filt, m_rf, m_ff;
  bit        m_ien, m_ovf;
  bit [15:0] m_ts;

  always @(posedge clk) begin : model
    bit [6:0] edges;
    bit       wr_c, wr_s, rd_e;
    int       pushes;
    ev_t      e;
    if (!rst_n) begin
      m_n = 0; m_p = 0; m_pc = 0; cyc = 0;
      m_ren = '0; m_fen = '0; m_filt = '0; m_rf = '0; m_ff = '0;
      m_ien = 1'b0; m_ovf = 1'b0; m_ts = '0;
      for (int i = 0; i < 7; i++) m_run[i] = 0;
      mq.delete();
    end else begin
      cyc++;
      wr_c = (data_write_n == 2'b10) && (address == 6'h00);
      wr_s = (data_write_n == 2'b10) && (address == 6'h04);
      rd_e = (data_read_n == 2'b10) && (address == 6'h08);
      edges = '0;
      for (int i = 0; i < 7; i++) begin
        if (ui_in[i] != m_filt[i]) begin
          m_run[i]++;
          if (m_run[i] == m_n + 1) begin
            edges[i]  = 1'b1;
            m_filt[i] = ui_in[i];
            m_run[i]  = 0;
          end
        end else begin
          m_run[i] = 0;
        end
        if (wr_c) m_run[i] = 0;
      end
      if (rd_e && mq.size() > 0) void'(mq.pop_front());
      if (wr_s) begin
        if (data_in[3]) m_ovf = 1'b0;
        m_rf &= ~data_in[14:8];
        m_ff &= ~data_in[22:16];
      end
      m_rf |= edges & m_filt;
      m_ff |= edges & ~m_filt;
      pushes = 0;
      for (int i = 0; i < 7; i++) begin
        if (edges[i] && (m_filt[i] ? m_ren[i] : m_fen[i])) begin
          if (pushes > 0 || mq.size() >= DEPTH) begin
            m_ovf = 1'b1;
          end else begin
            e.level = m_filt[i];
            e.idx   = 3'(i);
            e.ts    = m_ts;
            mq.push_back(e);
          end
          pushes++;
        end
      end
      m_pc++;
      if (m_pc > m_p) begin
        m_pc = 0;
        m_ts++;
      end
      if (wr_c) begin
        m_n   = int'(data_in[3:0]);
        m_p   = int'(data_in[7:4]);
        m_ren = data_in[14:8];
        m_fen = data_in[22:16];
        m_ien = data_in[31];
      end
    end
  end

  function automatic logic [31:0] exp_dout(input logic [5:0] a);
    logic [31:0] r;
    r = '0;
    case (a)
      6'h00: r = {m_ien, 8'b0, m_fen, 1'b0, m_ren, 4'(m_p), 4'(m_n)};
      6'h04: r = {9'b0, m_ff, 1'b0, m_rf, 4'b0, m_ovf, 3'(mq.size())};
      6'h08: if (mq.size() > 0) r = {1'b1, 10'b0, mq[0].level, 1'b0, mq[0].idx, mq[0].ts};
      6'h0C: r = {16'b0, m_ts};
      default: r = '0;
    endcase
    return r;
  endfunction

  always @(negedge clk) begin
    if (rst_n) begin
      chk("filt_out", 32'(filt_out), 32'(m_filt));
      chk("irq", 32'(irq), 32'(m_ien && (mq.size() != 0 || m_ovf)));
      chk("data_out", data_out, exp_dout(address));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [5:0] a, input logic [31:0] d);
    address      = a;
    data_in      = d;
    data_write_n = 2'b10;
    tick();
    data_write_n = 2'b11;
  endtask

  logic [15:0] ev_ts;

  initial begin
    // Reset with random inputs
    rst_n = 1'b0;
    repeat (3) begin
      ui_in = 7'($urandom);
      tick();
    end
    chk("rst_filt", 32'(filt_out), 32'h0);
    chk("rst_irq", 32'(irq), 32'h0);
    chk("data_ready", 32'(data_ready), 32'h1);
    address = 6'h00; #1 chk("rst_ctrl", data_out, 32'h0);
    address = 6'h04; #1 chk("rst_status", data_out, 32'h0);
    address = 6'h08; #1 chk("rst_event", data_out, 32'h0);
    address = 6'h0C; #1 chk("rst_ts", data_out, 32'h0);
    ui_in = '0;
    tick();
    rst_n = 1'b1;
    tick();

    // Filter with N=3
    wr(6'h00, 32'h0000_0003);
    ui_in[2] = 1'b1;
    repeat (3) tick();
    chk("filt_hold3", 32'(filt_out[2]), 32'h0);
    tick();
    chk("filt_4th", 32'(filt_out[2]), 32'h1);
    address = 6'h04; #1 chk("rise_flag2", data_out, 32'h0000_0400);
    ui_in[2] = 1'b0;
    repeat (4) tick();
    chk("fall_flag2", data_out, 32'h0004_0400);
    wr(6'h04, 32'h007F_7F08);
    chk("flags_clr", data_out, 32'h0);
    address = 6'h10; #1 chk("unmapped", data_out, 32'h0);

    // Event capture
    wr(6'h00, 32'h8000_0200);
    ui_in[1] = 1'b1;
    tick();
    ev_ts = 16'(cyc - 1);
    address = 6'h04; #1 chk("ev_status", data_out, 32'h0000_0201);
    chk("ev_irq", 32'(irq), 32'h1);
    address = 6'h08; data_read_n = 2'b10; #1 chk("ev_read", data_out, {16'h8011, ev_ts});
    tick();
    data_read_n = 2'b11;
    chk("ev_empty", data_out, 32'h0);
    chk("ev_irq_clr", 32'(irq), 32'h0);
    ui_in[1] = 1'b0;
    tick();
    wr(6'h04, 32'h007F_7F08);

    // Overflow, prescaler 2
    wr(6'h00, 32'h8001_0120);
    address = 6'h00; #1 chk("ctrl_rb", data_out, 32'h8001_0120);
    for (int i = 0; i < 5; i++) begin
      ui_in[0] = ~ui_in[0];
      tick();
    end
    address = 6'h04; #1 chk("ovf_full", data_out, 32'h0001_010C);
    chk("ovf_irq", 32'(irq), 32'h1);
    wr(6'h04, 32'h0000_0008);
    chk("ovf_clr", data_out, 32'h0001_0104);

    // Drain, then simultaneous rises on bits 0 and 3
    address = 6'h08; data_read_n = 2'b10;
    repeat (4) tick();
    data_read_n = 2'b11;
    wr(6'h00, 32'h8000_0900);
    ui_in[0] = 1'b0;
    tick();
    wr(6'h04, 32'h007F_7F08);
    ui_in[0] = 1'b1; ui_in[3] = 1'b1;
    tick();
    chk("simul_status", data_out, 32'h0000_0909);
    address = 6'h08; #1 chk("simul_head", 32'(data_out[31:16]), 32'h0000_8010);
    wr(6'h04, 32'h0000_0008);
    repeat (3) begin
      ui_in[0] = 1'b0; tick();
      ui_in[0] = 1'b1; tick();
    end
    chk("fill_status", data_out, 32'h0001_0904);
    ui_in[3] = 1'b0;
    tick();
    address = 6'h08; data_read_n = 2'b10; ui_in[3] = 1'b1;
    tick();
    data_read_n = 2'b11;
    address = 6'h04; #1 chk("poppush_status", data_out, 32'h0009_0904);
    address = 6'h08;
    for (int j = 0; j < 4; j++) begin
      if (j == 3) chk("tail_idx3", 32'(data_out[31:16]), 32'h0000_8013);
      data_read_n = 2'b10;
      tick();
      data_read_n = 2'b11;
    end

    // Asynchronous reset mid-operation
    ui_in[0] = 1'b0; tick();
    ui_in[0] = 1'b1; tick();
    wr(6'h00, 32'h8000_0903);
    ui_in[3] = 1'b0;
    repeat (2) tick();
    address = 6'h04;
    #3 rst_n = 1'b0;
    #1;
    chk("arst_filt", 32'(filt_out), 32'h0);
    chk("arst_irq", 32'(irq), 32'h0);
    chk("arst_status", data_out, 32'h0);
    repeat (2) tick();
    ui_in = '0;
    rst_n = 1'b1;
    repeat (3) tick();
    chk("post_rst_status", data_out, 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
